// File: rtl/axis_packet_fifo.sv
// ---------------------------------------------------------------------------
// axis_packet_fifo
//
// AXI-Stream FIFO carrying {tlast, tkeep, tdata} through a circular buffer.
// PACKET_MODE=0 forwards word by word (cut-through); PACKET_MODE=1 holds
// words back until a complete frame (tlast) is stored, with a full-buffer
// override so frames longer than DEPTH still drain. Reports fill level,
// stored-frame count and programmable almost-full / almost-empty flags.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axis_t*             slave (input) stream: tdata, tkeep, tlast, tvalid, tready
//   m_axis_t*             master (output) stream, first-word fall-through
//   level                 number of stored words (0..DEPTH)
//   pkt_count             number of stored words carrying tlast
//   almost_full           level >= ALMOST_FULL_THRESH
//   almost_empty          level <= ALMOST_EMPTY_THRESH
// ---------------------------------------------------------------------------
module axis_packet_fifo #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned DEPTH               = 16,
    parameter int unsigned PACKET_MODE         = 0,
    parameter int unsigned ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [$clog2(DEPTH):0]    pkt_count,
    output logic                      almost_full,
    output logic                      almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned KW = DATA_WIDTH / 8;
    localparam int unsigned EW = 1 + KW + DATA_WIDTH;

    logic [EW-1:0] r_mem [DEPTH];

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   r_pkt_count;

    logic [AW:0]   w_level_next;
    logic [AW:0]   w_pkt_next;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;
    logic          w_wr_last;
    logic          w_rd_last;
    logic          w_valid;
    logic [EW-1:0] w_rd_entry;

    assign w_full  = (r_level == PW'(DEPTH));
    assign w_empty = (r_level == '0);

    // Ready depends only on registered level, never on tvalid/tready.
    assign s_axis_tready = !areset && !w_full;

    // Full-without-tlast override keeps an oversize frame from deadlocking.
    always_comb begin
        w_valid = !w_empty;
        if (PACKET_MODE != 0) begin
            w_valid = (r_pkt_count != '0) || w_full;
        end
    end
    assign m_axis_tvalid = w_valid;

    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = w_rd_entry;

    assign w_wr      = s_axis_tvalid && s_axis_tready;
    assign w_rd      = w_valid && m_axis_tready;
    assign w_wr_last = w_wr && s_axis_tlast;
    assign w_rd_last = w_rd && m_axis_tlast;

    always_comb begin
        w_level_next = r_level;
        unique case ({w_wr, w_rd})
            2'b10:   w_level_next = r_level + PW'(1);
            2'b01:   w_level_next = r_level - PW'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_comb begin
        w_pkt_next = r_pkt_count;
        unique case ({w_wr_last, w_rd_last})
            2'b10:   w_pkt_next = r_pkt_count + PW'(1);
            2'b01:   w_pkt_next = r_pkt_count - PW'(1);
            default: w_pkt_next = r_pkt_count;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level     <= w_level_next;
            r_pkt_count <= w_pkt_next;
        end
    end

    assign level        = r_level;
    assign pkt_count    = r_pkt_count;
    assign almost_full  = (r_level >= PW'(ALMOST_FULL_THRESH));
    assign almost_empty = (r_level <= PW'(ALMOST_EMPTY_THRESH));

endmodule

// File: tb/tb_axis_packet_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_fifo
//
// Directed bench for axis_packet_fifo. Instance u_ct runs cut-through
// (PACKET_MODE=0), instance u_sf runs store-and-forward (PACKET_MODE=1);
// both use DATA_WIDTH=32, DEPTH=16 and share clock and reset.
// ---------------------------------------------------------------------------
module tb_axis_packet_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned LW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Cut-through instance signals
    logic [DW-1:0] a_sd, a_md;
    logic [KW-1:0] a_sk, a_mk;
    logic          a_sl, a_sv, a_sr, a_ml, a_mv, a_mr;
    logic [LW-1:0] a_lvl, a_pkt;
    logic          a_af, a_ae;

    // Store-and-forward instance signals
    logic [DW-1:0] b_sd, b_md;
    logic [KW-1:0] b_sk, b_mk;
    logic          b_sl, b_sv, b_sr, b_ml, b_mv, b_mr;
    logic [LW-1:0] b_lvl, b_pkt;
    logic          b_af, b_ae;

    axis_packet_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) u_ct (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl),
        .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
        .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
        .m_axis_tvalid(a_mv), .m_axis_tready(a_mr),
        .level(a_lvl), .pkt_count(a_pkt), .almost_full(a_af), .almost_empty(a_ae)
    );

    axis_packet_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(1)) u_sf (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl),
        .s_axis_tvalid(b_sv), .s_axis_tready(b_sr),
        .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
        .m_axis_tvalid(b_mv), .m_axis_tready(b_mr),
        .level(b_lvl), .pkt_count(b_pkt), .almost_full(b_af), .almost_empty(b_ae)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] bp_data(input int k);
        return 32'hC0DE_0000 + DW'(k);
    endfunction

    function automatic logic [KW-1:0] bp_keep(input int k);
        return (k % 2 == 1) ? 4'h3 : 4'hF;
    endfunction

    function automatic logic bp_last(input int k);
        return (k % 4 == 3);
    endfunction

    initial begin
        int  wr;
        int  rd;
        bit  w;
        bit  seen;
        bit  hold;
        logic [DW-1:0] pd;
        logic [KW-1:0] pk;
        logic          pl;

        rst  = 1'b1;
        a_sd = '0; a_sk = '0; a_sl = 1'b0; a_sv = 1'b0; a_mr = 1'b0;
        b_sd = '0; b_sk = '0; b_sl = 1'b0; b_sv = 1'b0; b_mr = 1'b0;
        step();
        step();

        // Reset state
        check("rst_sready", a_sr, 0);
        check("rst_level", a_lvl, 0);
        check("rst_pkt", a_pkt, 0);
        check("rst_mvalid", a_mv, 0);
        check("rst_aempty", a_ae, 1);
        check("rst_afull", a_af, 0);
        check("rst_sf_mvalid", b_mv, 0);
        rst = 1'b0;
        step();
        check("post_rst_sready", a_sr, 1);

        // Single word, 1-cycle latency
        a_sv = 1'b1; a_sd = 32'hA5A5_0001; a_sk = 4'hF; a_sl = 1'b1;
        step();
        a_sv = 1'b0; a_sl = 1'b0;
        check("single_mvalid", a_mv, 1);
        check("single_data", a_md, 32'hA5A5_0001);
        check("single_last", a_ml, 1);
        check("single_level", a_lvl, 1);
        check("single_pkt", a_pkt, 1);
        a_mr = 1'b1;
        step();
        a_mr = 1'b0;
        check("single_rd_level", a_lvl, 0);
        check("single_rd_aempty", a_ae, 1);
        check("single_rd_mvalid", a_mv, 0);

        // Fill to full with output stalled
        a_sv = 1'b1; a_sk = 4'hF; a_sl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_sd = DW'(i);
            step();
        end
        a_sv = 1'b0;
        check("full_sready", a_sr, 0);
        check("full_level", a_lvl, 16);
        check("full_afull", a_af, 1);
        check("full_head", a_md, 0);

        // Stream through pointer wrap with both sides ready
        wr = 16; rd = 0;
        a_mr = 1'b1; a_sv = 1'b1; a_sd = DW'(wr);
        for (int c = 0; c < 200 && rd < 40; c++) begin
            if (a_mv) begin
                check("wrap_data", a_md, DW'(rd));
                rd++;
            end
            w = a_sv && a_sr;
            step();
            if (w) begin
                wr++;
                if (wr == 40) a_sv = 1'b0;
                a_sd = DW'(wr);
            end
            if (c == 10) check("wrap_level_const", a_lvl, 15);
        end
        a_mr = 1'b0;
        check("wrap_count", rd, 40);
        check("wrap_level_end", a_lvl, 0);

        // Store-and-forward gating on a 5-word frame
        b_sv = 1'b1; b_sk = 4'hF;
        for (int i = 0; i < 5; i++) begin
            b_sd = 32'h100 + DW'(i);
            b_sl = (i == 4);
            step();
            if (i < 4) check("pkt_gate", b_mv, 0);
        end
        b_sv = 1'b0; b_sl = 1'b0;
        check("pkt_valid", b_mv, 1);
        check("pkt_count1", b_pkt, 1);
        b_mr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("pkt_rd_data", b_md, 32'h100 + DW'(i));
            check("pkt_rd_last", b_ml, (i == 4));
            check("pkt_rd_count", b_pkt, 1);
            step();
        end
        b_mr = 1'b0;
        check("pkt_count0", b_pkt, 0);
        check("pkt_drained_mvalid", b_mv, 0);

        // Oversize frame: 20 words, tlast only on the last
        wr = 0; rd = 0; seen = 1'b0;
        b_mr = 1'b1; b_sv = 1'b1; b_sk = 4'hF;
        b_sd = 32'h200; b_sl = 1'b0;
        for (int c = 0; c < 400 && rd < 20; c++) begin
            if (b_mv) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("over_first_level", b_lvl, 16);
                end
                check("over_data", b_md, 32'h200 + DW'(rd));
                check("over_last", b_ml, (rd == 19));
                rd++;
            end
            w = b_sv && b_sr;
            step();
            if (w) begin
                wr++;
                if (wr == 20) b_sv = 1'b0;
                b_sd = 32'h200 + DW'(wr);
                b_sl = (wr == 19);
            end
        end
        b_mr = 1'b0; b_sl = 1'b0;
        check("over_count", rd, 20);
        check("over_pkt_end", b_pkt, 0);
        check("over_level_end", b_lvl, 0);

        // Random backpressure, stability and scoreboard over 100 words
        wr = 0; rd = 0; hold = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        a_sv = 1'b1; a_sd = bp_data(0); a_sk = bp_keep(0); a_sl = bp_last(0);
        for (int c = 0; c < 3000 && rd < 100; c++) begin
            if (hold) begin
                check("bp_hold_valid", a_mv, 1);
                check("bp_hold_data", a_md, pd);
                check("bp_hold_keep", a_mk, pk);
                check("bp_hold_last", a_ml, pl);
            end
            a_mr = ($urandom_range(0, 9) < 3);
            if (a_mv && a_mr) begin
                check("bp_data", a_md, bp_data(rd));
                check("bp_keep", a_mk, bp_keep(rd));
                check("bp_last", a_ml, bp_last(rd));
                rd++;
            end
            hold = a_mv && !a_mr;
            pd = a_md; pk = a_mk; pl = a_ml;
            w = a_sv && a_sr;
            step();
            if (w) begin
                wr++;
                if (wr == 100) a_sv = 1'b0;
                a_sd = bp_data(wr); a_sk = bp_keep(wr); a_sl = bp_last(wr);
            end
        end
        a_mr = 1'b0; a_sv = 1'b0; a_sl = 1'b0;
        check("bp_count", rd, 100);
        check("bp_level_end", a_lvl, 0);

        // Reset mid-operation with 7 words / 2 frames stored
        a_sv = 1'b1; a_sk = 4'hF;
        for (int i = 0; i < 7; i++) begin
            a_sd = DW'(i);
            a_sl = (i == 1 || i == 4);
            step();
        end
        a_sv = 1'b0; a_sl = 1'b0;
        check("mid_level7", a_lvl, 7);
        check("mid_pkt2", a_pkt, 2);
        rst = 1'b1;
        step();
        check("mid_rst_level", a_lvl, 0);
        check("mid_rst_pkt", a_pkt, 0);
        check("mid_rst_mvalid", a_mv, 0);
        check("mid_rst_sready", a_sr, 0);
        rst = 1'b0;
        #1;
        check("mid_release_sready", a_sr, 1);
        step();
        check("mid_after_mvalid", a_mv, 0);
        check("mid_after_level", a_lvl, 0);
        check("mid_after_aempty", a_ae, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Parametrised AXI-Stream FIFO, successor to the single-mode stream FIFO.
- Adds TLAST/TKEEP transport, an optional store-and-forward packet mode, fill-level reporting and programmable almost-full/almost-empty flags.
- Sits between LFSR/data-source stages and downstream AXI-Stream consumers as a rate-decoupling or packet-gating buffer.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
- DEPTH, 16, entry count; power of two, >= 4.
- PACKET_MODE, 0, 0 = cut-through (word granularity); 1 = store-and-forward (frame granularity).
- ALMOST_FULL_THRESH, DEPTH-2, almost_full asserts when level >= this value.
- ALMOST_EMPTY_THRESH, 2, almost_empty asserts when level <= this value.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  DATA_WIDTH/8  input byte enables; stored unmodified.
- s_axis_tlast  in  1  end-of-packet marker.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- level  out  $clog2(DEPTH)+1  number of stored words.
- pkt_count  out  $clog2(DEPTH)+1  number of complete packets stored (tlast words held).
- almost_full  out  1  level >= ALMOST_FULL_THRESH.
- almost_empty  out  1  level <= ALMOST_EMPTY_THRESH.

Behaviour:
- Interface: one clock (aclk); synchronous active-high reset (areset).
- Storage: circular buffer of {tlast, tkeep, tdata}. Pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty; the low bits address memory and wrap from DEPTH-1 to 0.
- Reset (areset=1 at an edge): pointers, level and pkt_count are 0; m_axis_tvalid=0; s_axis_tready=0 while areset is high, and 1 in the first cycle after release; almost_empty=1; almost_full=0. Memory contents are not reset.
- Write: occurs when s_axis_tvalid && s_axis_tready. s_axis_tready = !areset && (level != DEPTH). It is derived only from registered state, with no combinational path from s_axis_tvalid or m_axis_tready.
- Read: occurs when m_axis_tvalid && m_axis_tready. The output is first-word fall-through: m_axis_tdata/tkeep/tlast always present the entry at the read pointer.
- m_axis_tvalid, PACKET_MODE=0: level != 0. A word written at edge N is valid in the cycle after N, i.e. 1-cycle latency.
- m_axis_tvalid, PACKET_MODE=1: (pkt_count != 0) || (level == DEPTH).
  - Words become valid in the cycle after the edge that writes the tlast word.
  - The full-without-tlast override prevents deadlock on packets longer than DEPTH; that packet then drains cut-through.
- level: +1 on write only, -1 on read only, unchanged on simultaneous read and write or on idle.
- pkt_count: +1 on a write with tlast=1, -1 on a read with tlast=1, unchanged when both happen in the same cycle.
- almost_full/almost_empty: combinational from registered level.
- Once m_axis_tvalid is high, m_axis_tdata/tkeep/tlast must hold stable until a read occurs (AXI rule).
- Simultaneous read and write when full: not possible, because s_axis_tready=0 at full. When full, a read frees a slot that is accepted on the next cycle.
- Simultaneous read and write when empty, PACKET_MODE=0: not possible, because m_axis_tvalid=0 at empty. The write lands and the word is valid next cycle.
- Reset asserted mid-packet: all stored data is discarded; the partial packet is lost; no output is produced after reset until new writes occur.

Test Plan:
- Reset then single word: DEPTH=16, PACKET_MODE=0; write 0xA5A5_0001 with tlast=1 at edge N -> m_axis_tvalid=1 at N+1 with data 0xA5A5_0001, tlast=1, level=1, pkt_count=1; read -> level=0, almost_empty=1.
- Fill to full, then wrap:
  - Write 16 words 0..15 with m_axis_tready=0 -> s_axis_tready=0, level=16, almost_full=1.
  - Then stream 40 words with both sides always ready -> output matches order 0..39 across pointer wrap; level stays constant.
- Packet gating, PACKET_MODE=1:
  - Write a 5-word packet with tlast on word 5 -> m_axis_tvalid stays 0 through word 4 and rises the cycle after word 5 is written.
  - Read 5 words -> pkt_count goes 1 to 0 and tlast is seen on the 5th word only.
- Oversize packet, PACKET_MODE=1: write 20 words, no tlast until word 20, with m_axis_tready=1 -> m_axis_tvalid asserts when level reaches 16; all 20 words delivered in order; no deadlock.
- Backpressure stability: random m_axis_tready with 30% duty -> tdata/tkeep/tlast are unchanged while valid is high and ready is low; scoreboard matches 100 words including tkeep patterns 0xF and 0x3.
- Reset mid-operation: assert areset for 1 cycle with level=7 and pkt_count=2 -> next cycle level=0, pkt_count=0, m_axis_tvalid=0, s_axis_tready=1 the cycle after release.
